// File: rtl/flowing_led_engine.sv
// Multi-mode flowing-LED generator: dot bounce, seed bounce, rotate and fill/drain
// patterns stepped by a built-in prescaler, with pause, reload and end-of-travel pulse.
module flowing_led_engine #(
    parameter int N_LED    = 16,
    parameter int TICK_DIV = 25_000_000
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [N_LED-1:0] seed,
    output logic [N_LED-1:0] led_out,
    output logic             dir,
    output logic             tick,
    output logic             end_pulse
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [N_LED-1:0] ONE_HOT0 = {{(N_LED-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        DOT_BOUNCE  = 2'd0,
        SEED_BOUNCE = 2'd1,
        ROTATE      = 2'd2,
        FILL_DRAIN  = 2'd3
    } mode_e;

    mode_e            mode_in, mode_q, mode_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [N_LED-1:0] led_d, step_led, sh_up, sh_dn;
    logic             dir_d, tick_d, end_d, step_dir, step_end;

    assign mode_in = mode_e'(mode);
    assign sh_up   = {led_out[N_LED-2:0], 1'b0};
    assign sh_dn   = {1'b0, led_out[N_LED-1:1]};

    function automatic logic [N_LED-1:0] init_pattern(input mode_e m, input logic [N_LED-1:0] s);
        case (m)
            DOT_BOUNCE:          init_pattern = ONE_HOT0;
            SEED_BOUNCE, ROTATE: init_pattern = s;
            default:             init_pattern = '0;
        endcase
    endfunction

    // Pattern advance for one step, evaluated from the latched mode only.
    always_comb begin
        step_led = led_out;
        step_dir = dir;
        step_end = 1'b0;
        case (mode_q)
            DOT_BOUNCE, SEED_BOUNCE: begin
                if (led_out == '0) begin
                    step_led = led_out;
                end else if (led_out[N_LED-1] && led_out[0]) begin
                    step_dir = ~dir;
                    step_end = 1'b1;
                end else if (dir) begin
                    if (!led_out[N_LED-1]) begin
                        step_led = sh_up;
                    end else begin
                        step_dir = 1'b0;
                        step_led = sh_dn;
                        step_end = 1'b1;
                    end
                end else begin
                    if (!led_out[0]) begin
                        step_led = sh_dn;
                    end else begin
                        step_dir = 1'b1;
                        step_led = sh_up;
                        step_end = 1'b1;
                    end
                end
            end
            ROTATE: begin
                step_dir = 1'b1;
                step_led = {led_out[N_LED-2:0], led_out[N_LED-1]};
                step_end = led_out[N_LED-1];
            end
            default: begin
                if (dir) begin
                    if (led_out != '1) begin
                        step_led = {led_out[N_LED-2:0], 1'b1};
                    end else begin
                        step_dir = 1'b0;
                        step_led = sh_dn;
                        step_end = 1'b1;
                    end
                end else begin
                    if (led_out != '0) begin
                        step_led = sh_dn;
                    end else begin
                        step_dir = 1'b1;
                        step_led = ONE_HOT0;
                        step_end = 1'b1;
                    end
                end
            end
        endcase
    end

    // Priority: mode change > load > stop > prescaler step.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt;
        led_d  = led_out;
        dir_d  = dir;
        tick_d = 1'b0;
        end_d  = 1'b0;
        if (mode_in != mode_q) begin
            mode_d = mode_in;
            cnt_d  = '0;
            dir_d  = 1'b1;
            led_d  = init_pattern(mode_in, seed);
        end else if (load) begin
            cnt_d = '0;
            dir_d = 1'b1;
            led_d = init_pattern(mode_q, seed);
        end else if (!stop) begin
            if (cnt == CNT_MAX) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                led_d  = step_led;
                dir_d  = step_dir;
                end_d  = step_end;
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            mode_q    <= DOT_BOUNCE;
            cnt       <= '0;
            led_out   <= ONE_HOT0;
            dir       <= 1'b1;
            tick      <= 1'b0;
            end_pulse <= 1'b0;
        end else begin
            mode_q    <= mode_d;
            cnt       <= cnt_d;
            led_out   <= led_d;
            dir       <= dir_d;
            tick      <= tick_d;
            end_pulse <= end_d;
        end
    end

endmodule

// File: tb/tb_flowing_led_engine.sv
// Self-checking bench for flowing_led_engine: directed pattern sequences plus
// randomized stop/load/mode/seed traffic checked against a cycle-level model.
module tb_flowing_led_engine;

    localparam int N  = 4;
    localparam int TD = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, stop, load;
    logic [1:0]   mode;
    logic [N-1:0] seed, led;
    logic         dir, tick, ep;

    logic       rst2;
    logic       stop2 = 1'b0, load2 = 1'b0;
    logic [1:0] mode2 = 2'd0;
    logic [1:0] seed2 = 2'd0;
    logic [1:0] led2;
    logic       dir2, tick2, ep2;

    int total = 0;
    int bad   = 0;

    int m_led, m_cnt, m_mq;
    bit m_dir, m_tick, m_ep;

    flowing_led_engine #(.N_LED(N), .TICK_DIV(TD)) dut (
        .clk_50MHz(clk), .rst(rst), .stop(stop), .mode(mode), .load(load),
        .seed(seed), .led_out(led), .dir(dir), .tick(tick), .end_pulse(ep)
    );

    flowing_led_engine #(.N_LED(2), .TICK_DIV(1)) dut2 (
        .clk_50MHz(clk), .rst(rst2), .stop(stop2), .mode(mode2), .load(load2),
        .seed(seed2), .led_out(led2), .dir(dir2), .tick(tick2), .end_pulse(ep2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int init_of(input int m, input int s);
        case (m)
            0:       return 1;
            1, 2:    return s;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_led = 1; m_dir = 1; m_cnt = 0; m_mq = 0; m_tick = 0; m_ep = 0;
    endtask

    task automatic model_pattern_step();
        int full, top;
        full = (1 << N) - 1;
        top  = 1 << (N - 1);
        case (m_mq)
            0, 1: begin
                if (m_led == 0) m_ep = 0;
                else if ((m_led & top) != 0 && (m_led & 1) != 0) begin m_dir = !m_dir; m_ep = 1; end
                else if (m_dir) begin
                    if ((m_led & top) == 0) begin m_led = (m_led * 2) & full; m_ep = 0; end
                    else begin m_dir = 0; m_led = m_led / 2; m_ep = 1; end
                end else begin
                    if ((m_led & 1) == 0) begin m_led = m_led / 2; m_ep = 0; end
                    else begin m_dir = 1; m_led = (m_led * 2) & full; m_ep = 1; end
                end
            end
            2: begin
                m_ep  = (m_led & top) != 0;
                m_led = ((m_led * 2) & full) | (m_ep ? 1 : 0);
                m_dir = 1;
            end
            default: begin
                if (m_dir) begin
                    if (m_led != full) begin m_led = (m_led * 2 + 1) & full; m_ep = 0; end
                    else begin m_dir = 0; m_led = m_led / 2; m_ep = 1; end
                end else begin
                    if (m_led != 0) begin m_led = m_led / 2; m_ep = 0; end
                    else begin m_dir = 1; m_led = 1; m_ep = 1; end
                end
            end
        endcase
    endtask

    task automatic model_edge();
        m_tick = 0; m_ep = 0;
        if (int'(mode) != m_mq) begin
            m_mq = int'(mode); m_cnt = 0; m_dir = 1; m_led = init_of(m_mq, int'(seed));
        end else if (load) begin
            m_cnt = 0; m_dir = 1; m_led = init_of(m_mq, int'(seed));
        end else if (!stop) begin
            if (m_cnt == TD - 1) begin
                m_cnt = 0; m_tick = 1; model_pattern_step();
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".led"}, 32'(led), 32'(m_led));
        chk({tag, ".dir"}, 32'(dir), 32'(m_dir));
        chk({tag, ".tick"}, 32'(tick), 32'(m_tick));
        chk({tag, ".end"}, 32'(ep), 32'(m_ep));
    endtask

    task automatic run(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            model_edge();
            #1;
            check_all(tag);
        end
    endtask

    // Record led/end_pulse on each of the next n ticks, with a cycle budget.
    task automatic run_ticks(input int n, input string tag, output int leds[16], output int eps[16]);
        int got, budget;
        got = 0; budget = n * TD * 4;
        for (int i = 0; i < 16; i++) begin leds[i] = -1; eps[i] = -1; end
        while (got < n && budget > 0) begin
            run(1, tag);
            budget--;
            if (tick === 1'b1) begin leds[got] = int'(led); eps[got] = int'(ep); got++; end
        end
        chk({tag, ".tick_count"}, 32'(got), 32'(n));
    endtask

    int leds[16], eps[16];
    int exp_m0_led[7] = '{2, 4, 8, 4, 2, 1, 2};
    int exp_m0_ep[7]  = '{0, 0, 0, 1, 0, 0, 1};
    int exp_m3_led[10] = '{1, 3, 7, 15, 7, 3, 1, 0, 1, 3};

    initial begin
        rst = 1'b1; stop = 1'b0; load = 1'b0; mode = 2'd0; seed = '0; rst2 = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        // Dot bounce from reset.
        run_ticks(7, "m0", leds, eps);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("m0_seq%0d.led", i), 32'(leds[i]), 32'(exp_m0_led[i]));
            chk($sformatf("m0_seq%0d.end", i), 32'(eps[i]), 32'(exp_m0_ep[i]));
        end

        // Seed bounce.
        mode = 2'd1; seed = 4'b0011;
        run(40, "m1");

        // Fill/drain.
        mode = 2'd3;
        run_ticks(10, "m3", leds, eps);
        for (int i = 0; i < 10; i++)
            chk($sformatf("m3_seq%0d.led", i), 32'(leds[i]), 32'(exp_m3_led[i]));

        // Rotate with pause.
        mode = 2'd2; seed = 4'b1001;
        run(1, "m2_load");
        stop = 1'b1;
        run(10, "m2_stop");
        chk("m2_frozen.led", 32'(led), 32'h9);
        stop = 1'b0;
        run_ticks(2, "m2_run", leds, eps);
        chk("m2_first.led", 32'(leds[0]), 32'h3);
        chk("m2_first.end", 32'(eps[0]), 32'h1);
        chk("m2_second.led", 32'(leds[1]), 32'h6);
        chk("m2_second.end", 32'(eps[1]), 32'h0);

        // Mode change honoured while paused.
        mode = 2'd0;
        run(9, "m0_again");
        stop = 1'b1; mode = 2'd3;
        run(1, "chg_stop");
        chk("chg_stop.led", 32'(led), 32'h0);
        chk("chg_stop.dir", 32'(dir), 32'h1);
        stop = 1'b0;
        run(2, "pre_load");
        load = 1'b1;
        run(1, "load");
        load = 1'b0;
        run(8, "post_load");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            stop = ($urandom % 8) == 0;
            load = ($urandom % 24) == 0;
            if (($urandom % 40) == 0) mode = 2'($urandom);
            seed = N'($urandom);
            run(1, "rand");
        end
        stop = 1'b0; load = 1'b0;

        // Asynchronous reset mid-cycle.
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.led", 32'(led), 32'h1);
        chk("async_rst.dir", 32'(dir), 32'h1);
        chk("async_rst.tick", 32'(tick), 32'h0);
        chk("async_rst.end", 32'(ep), 32'h0);
        mode = 2'd0;
        #2 rst = 1'b0;
        run(12, "after_rst");

        // Two-LED instance stepping every cycle.
        rst2 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            chk("n2.led", 32'(led2), (k % 2 == 1) ? 32'h2 : 32'h1);
            chk("n2.end", 32'(ep2), (k >= 2) ? 32'h1 : 32'h0);
            chk("n2.tick", 32'(tick2), 32'h1);
        end
        #2 rst2 = 1'b1;
        #1;
        chk("n2_rst.led", 32'(led2), 32'h1);
        chk("n2_rst.tick", 32'(tick2), 32'h0);
        chk("n2_rst.end", 32'(ep2), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
